// File: rtl/avalon_mm_bridge.sv
// Avalon-MM pipeline bridge: one registered command slice toward the fabric,
// an outstanding-read limiter, and a one-cycle registered read-response path.
module avalon_mm_bridge #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   // upstream agent side
   input  logic [ADDR_W-1:0]     s_address,
   input  logic [DATA_W/8-1:0]   s_byteenable,
   input  logic                  s_read,
   input  logic                  s_write,
   input  logic [DATA_W-1:0]     s_writedata,
   output logic                  s_waitrequest,
   output logic [DATA_W-1:0]     s_readdata,
   output logic                  s_readdatavalid,
   // downstream host side
   output logic [ADDR_W-1:0]     m_address,
   output logic [DATA_W/8-1:0]   m_byteenable,
   output logic                  m_read,
   output logic                  m_write,
   output logic [DATA_W-1:0]     m_writedata,
   input  logic                  m_waitrequest,
   input  logic [DATA_W-1:0]     m_readdata,
   input  logic                  m_readdatavalid,
   output logic                  err_unsolicited
);

   localparam int BE_W   = DATA_W / 8;
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   // command slice
   logic              cmd_full_q, cmd_full_d;
   logic              cmd_read_q, cmd_read_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [BE_W-1:0]   cmd_be_q, cmd_be_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

   // read tracking and response path
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic at_limit;
   logic accept;
   logic read_accept;
   logic issue;
   logic resp_ok;

   // The m_waitrequest term is combinational so a draining slice refills in the same cycle.
   assign at_limit      = (pending_q == PEND_MAX);
   assign s_waitrequest = (cmd_full_q & m_waitrequest) | (s_read & at_limit);
   assign accept        = (s_read | s_write) & ~s_waitrequest;
   assign read_accept   = accept & s_read;
   assign issue         = cmd_full_q & ~m_waitrequest;
   assign resp_ok       = m_readdatavalid & (pending_q != '0);

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path can infer a latch.
      cmd_full_d  = cmd_full_q;
      cmd_read_d  = cmd_read_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_be_d    = cmd_be_q;
      cmd_wdata_d = cmd_wdata_q;
      pending_d   = pending_q;

      if (accept) begin
         cmd_full_d  = 1'b1;
         cmd_read_d  = s_read;  // read wins when both strobes are high
         cmd_addr_d  = s_address;
         cmd_be_d    = s_byteenable;
         cmd_wdata_d = s_writedata;
      end else if (issue) begin
         cmd_full_d  = 1'b0;
      end

      unique case ({read_accept, resp_ok})
         2'b10:   pending_d = pending_q + PEND_W'(1);
         2'b01:   pending_d = pending_q - PEND_W'(1);
         default: pending_d = pending_q;
      endcase

      rvalid_d = resp_ok;
      rdata_d  = resp_ok ? m_readdata : rdata_q;
      err_d    = err_q | (m_readdatavalid & (pending_q == '0));
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_full_q  <= 1'b0;
         cmd_read_q  <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_be_q    <= '0;
         cmd_wdata_q <= '0;
         pending_q   <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         cmd_full_q  <= cmd_full_d;
         cmd_read_q  <= cmd_read_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_be_q    <= cmd_be_d;
         cmd_wdata_q <= cmd_wdata_d;
         pending_q   <= pending_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign m_read          = cmd_full_q & cmd_read_q;
   assign m_write         = cmd_full_q & ~cmd_read_q;
   assign m_address       = cmd_addr_q;
   assign m_byteenable    = cmd_be_q;
   assign m_writedata     = cmd_wdata_q;
   assign s_readdata      = rdata_q;
   assign s_readdatavalid = rvalid_q;
   assign err_unsolicited = err_q;

endmodule

// File: tb/tb_avalon_mm_bridge.sv
// Self-checking bench for avalon_mm_bridge: directed scenarios plus a randomized
// run against a transaction-level model (command queue, outstanding count, response data).
module tb_avalon_mm_bridge;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int MAXP   = 4;

   typedef struct {
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wd;
   } cmd_t;

   logic              clk, rst;
   logic [ADDR_W-1:0] s_address;
   logic [BE_W-1:0]   s_byteenable;
   logic              s_read, s_write;
   logic [DATA_W-1:0] s_writedata;
   logic              s_waitrequest;
   logic [DATA_W-1:0] s_readdata;
   logic              s_readdatavalid;
   logic [ADDR_W-1:0] m_address;
   logic [BE_W-1:0]   m_byteenable;
   logic              m_read, m_write;
   logic [DATA_W-1:0] m_writedata;
   logic              m_waitrequest;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;
   logic              err_unsolicited;

   int n_cmp = 0;
   int n_bad = 0;

   avalon_mm_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
      .clk(clk), .rst(rst),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
      .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
      .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
      .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .err_unsolicited(err_unsolicited)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      s_address = '0; s_byteenable = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
      m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      #2;
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [ADDR_W-1:0] a;
      logic [BE_W-1:0]   be;
      #3;  // still before the first rising edge
      n_cmp++; if (s_waitrequest !== 1'b0)   begin n_bad++; $display("FAIL rst_s_waitrequest got %h want 0", s_waitrequest); end
      n_cmp++; if (m_read !== 1'b0)          begin n_bad++; $display("FAIL rst_m_read got %h want 0", m_read); end
      n_cmp++; if (m_write !== 1'b0)         begin n_bad++; $display("FAIL rst_m_write got %h want 0", m_write); end
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL rst_s_rdv got %h want 0", s_readdatavalid); end
      n_cmp++; if (err_unsolicited !== 1'b0) begin n_bad++; $display("FAIL rst_err got %h want 0", err_unsolicited); end
      n_cmp++; if (s_readdata !== '0)        begin n_bad++; $display("FAIL rst_s_readdata got %h want 0", s_readdata); end
      n_cmp++; if (m_address !== '0)         begin n_bad++; $display("FAIL rst_m_address got %h want 0", m_address); end
      n_cmp++; if (m_byteenable !== '0)      begin n_bad++; $display("FAIL rst_m_byteenable got %h want 0", m_byteenable); end
      n_cmp++; if (m_writedata !== '0)       begin n_bad++; $display("FAIL rst_m_writedata got %h want 0", m_writedata); end
      // first accept on the first edge after release
      a  = $urandom;
      be = BE_W'($urandom_range(1, 15));
      @(negedge clk);
      rst = 1'b1; s_read = 1'b1; s_address = a; s_byteenable = be;
      tick();
      s_read = 1'b0;
      n_cmp++; if (m_read !== 1'b1)     begin n_bad++; $display("FAIL first_accept_m_read got %h want 1", m_read); end
      n_cmp++; if (m_address !== a)     begin n_bad++; $display("FAIL first_accept_addr got %h want %h", m_address, a); end
      n_cmp++; if (m_byteenable !== be) begin n_bad++; $display("FAIL first_accept_be got %h want %h", m_byteenable, be); end
   endtask

   task automatic test_single_read();
      do_reset();
      s_read = 1'b1; s_address = 32'h100; s_byteenable = 4'hF;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL sr_wait got %h want 0", s_waitrequest); end
      tick();
      s_read = 1'b0;
      n_cmp++; if (m_read !== 1'b1)        begin n_bad++; $display("FAIL sr_m_read got %h want 1", m_read); end
      n_cmp++; if (m_write !== 1'b0)       begin n_bad++; $display("FAIL sr_m_write got %h want 0", m_write); end
      n_cmp++; if (m_address !== 32'h100)  begin n_bad++; $display("FAIL sr_m_address got %h want 100", m_address); end
      tick();
      n_cmp++; if (m_read !== 1'b0)        begin n_bad++; $display("FAIL sr_drained got %h want 0", m_read); end
      m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
      tick();
      m_readdatavalid = 1'b0; m_readdata = $urandom;
      n_cmp++; if (s_readdatavalid !== 1'b1)     begin n_bad++; $display("FAIL sr_rdv got %h want 1", s_readdatavalid); end
      n_cmp++; if (s_readdata !== 32'hDEADBEEF)  begin n_bad++; $display("FAIL sr_rdata got %h want deadbeef", s_readdata); end
      tick();
      n_cmp++; if (s_readdatavalid !== 1'b0)     begin n_bad++; $display("FAIL sr_rdv_drop got %h want 0", s_readdatavalid); end
      n_cmp++; if (s_readdata !== 32'hDEADBEEF)  begin n_bad++; $display("FAIL sr_rdata_hold got %h want deadbeef", s_readdata); end
      // pending back at zero: a further response is unsolicited
      m_readdatavalid = 1'b1;
      tick();
      m_readdatavalid = 1'b0;
      n_cmp++; if (err_unsolicited !== 1'b1) begin n_bad++; $display("FAIL sr_pending_zero_err got %h want 1", err_unsolicited); end
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL sr_pending_zero_rdv got %h want 0", s_readdatavalid); end
   endtask

   task automatic test_write();
      logic [ADDR_W-1:0] wa, ra;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wd;
      do_reset();
      wa = $urandom; ra = ~wa; be = BE_W'($urandom); wd = $urandom;
      s_write = 1'b1; s_address = wa; s_byteenable = be; s_writedata = wd;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL wr_wait got %h want 0", s_waitrequest); end
      tick();
      s_read = 1'b1; s_address = ra;  // both strobes: read only
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL wr_refill_wait got %h want 0", s_waitrequest); end
      n_cmp++; if (m_write !== 1'b1)       begin n_bad++; $display("FAIL wr_m_write got %h want 1", m_write); end
      n_cmp++; if (m_read !== 1'b0)        begin n_bad++; $display("FAIL wr_m_read got %h want 0", m_read); end
      n_cmp++; if (m_address !== wa)       begin n_bad++; $display("FAIL wr_addr got %h want %h", m_address, wa); end
      n_cmp++; if (m_byteenable !== be)    begin n_bad++; $display("FAIL wr_be got %h want %h", m_byteenable, be); end
      n_cmp++; if (m_writedata !== wd)     begin n_bad++; $display("FAIL wr_data got %h want %h", m_writedata, wd); end
      tick();
      s_read = 1'b0; s_write = 1'b0;
      n_cmp++; if (m_read !== 1'b1)        begin n_bad++; $display("FAIL rw_both_m_read got %h want 1", m_read); end
      n_cmp++; if (m_write !== 1'b0)       begin n_bad++; $display("FAIL rw_both_m_write got %h want 0", m_write); end
      n_cmp++; if (m_address !== ra)       begin n_bad++; $display("FAIL rw_both_addr got %h want %h", m_address, ra); end
   endtask

   task automatic test_backpressure();
      logic [ADDR_W-1:0] a, b;
      do_reset();
      a = $urandom; b = ~a;
      m_waitrequest = 1'b1;
      s_read = 1'b1; s_address = a;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL bp_empty_wait got %h want 0", s_waitrequest); end
      tick();
      s_address = b;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (s_waitrequest !== 1'b1) begin n_bad++; $display("FAIL bp_wait[%0d] got %h want 1", i, s_waitrequest); end
         n_cmp++; if (m_read !== 1'b1)        begin n_bad++; $display("FAIL bp_m_read[%0d] got %h want 1", i, m_read); end
         n_cmp++; if (m_address !== a)        begin n_bad++; $display("FAIL bp_addr[%0d] got %h want %h", i, m_address, a); end
         tick();
      end
      m_waitrequest = 1'b0;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL bp_release_wait got %h want 0", s_waitrequest); end
      tick();
      s_read = 1'b0;
      n_cmp++; if (m_read !== 1'b1)        begin n_bad++; $display("FAIL bp_b2b_m_read got %h want 1", m_read); end
      n_cmp++; if (m_address !== b)        begin n_bad++; $display("FAIL bp_b2b_addr got %h want %h", m_address, b); end
   endtask

   task automatic test_pending_limit();
      logic [ADDR_W-1:0] a5, wa;
      logic [DATA_W-1:0] wd, rd;
      do_reset();
      a5 = $urandom; wa = $urandom; wd = $urandom; rd = $urandom;
      for (int i = 0; i < MAXP; i++) begin
         s_read = 1'b1; s_address = 32'h1000 + 32'(i * 4);
         #1;
         n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL pl_rd%0d_wait got %h want 0", i, s_waitrequest); end
         tick();
      end
      s_address = a5;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b1) begin n_bad++; $display("FAIL pl_fifth_wait got %h want 1", s_waitrequest); end
      tick();
      n_cmp++; if (m_read !== 1'b0)        begin n_bad++; $display("FAIL pl_fifth_blocked got %h want 0", m_read); end
      s_read = 1'b0; s_write = 1'b1; s_address = wa; s_writedata = wd;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL pl_write_wait got %h want 0", s_waitrequest); end
      tick();
      s_write = 1'b0;
      n_cmp++; if (m_write !== 1'b1)       begin n_bad++; $display("FAIL pl_write_issue got %h want 1", m_write); end
      n_cmp++; if (m_writedata !== wd)     begin n_bad++; $display("FAIL pl_write_data got %h want %h", m_writedata, wd); end
      s_read = 1'b1; s_address = a5;
      m_readdatavalid = 1'b1; m_readdata = rd;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b1) begin n_bad++; $display("FAIL pl_full_with_resp_wait got %h want 1", s_waitrequest); end
      tick();
      m_readdatavalid = 1'b0;
      n_cmp++; if (s_readdatavalid !== 1'b1) begin n_bad++; $display("FAIL pl_resp_rdv got %h want 1", s_readdatavalid); end
      n_cmp++; if (s_readdata !== rd)        begin n_bad++; $display("FAIL pl_resp_data got %h want %h", s_readdata, rd); end
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0)   begin n_bad++; $display("FAIL pl_fifth_accept_wait got %h want 0", s_waitrequest); end
      tick();
      s_read = 1'b0;
      n_cmp++; if (m_read !== 1'b1)          begin n_bad++; $display("FAIL pl_fifth_m_read got %h want 1", m_read); end
      n_cmp++; if (m_address !== a5)         begin n_bad++; $display("FAIL pl_fifth_addr got %h want %h", m_address, a5); end
   endtask

   task automatic test_simultaneous();
      logic [DATA_W-1:0] rd;
      do_reset();
      rd = $urandom;
      s_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_address = $urandom;
         tick();
      end
      m_readdatavalid = 1'b1; m_readdata = rd;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL sim_wait got %h want 0", s_waitrequest); end
      tick();
      m_readdatavalid = 1'b0;
      n_cmp++; if (s_readdatavalid !== 1'b1) begin n_bad++; $display("FAIL sim_rdv got %h want 1", s_readdatavalid); end
      n_cmp++; if (s_readdata !== rd)        begin n_bad++; $display("FAIL sim_rdata got %h want %h", s_readdata, rd); end
      // pending should still be 2: two more reads fit, the next one stalls
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (s_waitrequest !== 1'b0) begin n_bad++; $display("FAIL sim_fill%0d_wait got %h want 0", i, s_waitrequest); end
         tick();
      end
      #1;
      n_cmp++; if (s_waitrequest !== 1'b1) begin n_bad++; $display("FAIL sim_limit_wait got %h want 1", s_waitrequest); end
      s_read = 1'b0;
   endtask

   task automatic test_unsolicited();
      do_reset();
      m_readdatavalid = 1'b1; m_readdata = $urandom;
      tick();
      m_readdatavalid = 1'b0;
      n_cmp++; if (err_unsolicited !== 1'b1) begin n_bad++; $display("FAIL un_err got %h want 1", err_unsolicited); end
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL un_rdv got %h want 0", s_readdatavalid); end
      tick();
      n_cmp++; if (err_unsolicited !== 1'b1) begin n_bad++; $display("FAIL un_sticky got %h want 1", err_unsolicited); end
      rst = 1'b0;
      #1;
      n_cmp++; if (err_unsolicited !== 1'b0) begin n_bad++; $display("FAIL un_reset_clear got %h want 0", err_unsolicited); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      n_cmp++; if (err_unsolicited !== 1'b0) begin n_bad++; $display("FAIL un_after_release got %h want 0", err_unsolicited); end
   endtask

   task automatic test_reset_midflight();
      logic [DATA_W-1:0] rd;
      do_reset();
      rd = $urandom | 32'h1;
      s_read = 1'b1;
      for (int i = 0; i < MAXP; i++) begin
         s_address = $urandom;
         tick();
      end
      s_read = 1'b0;
      m_readdatavalid = 1'b1; m_readdata = rd;
      tick();
      m_readdatavalid = 1'b0;
      m_waitrequest = 1'b1;
      s_write = 1'b1; s_address = $urandom | 32'h4; s_byteenable = 4'hF; s_writedata = $urandom | 32'h1;
      tick();
      s_write = 1'b0;
      n_cmp++; if (m_write !== 1'b1)    begin n_bad++; $display("FAIL mf_slice_full got %h want 1", m_write); end
      n_cmp++; if (s_readdata !== rd)   begin n_bad++; $display("FAIL mf_rdata_pre got %h want %h", s_readdata, rd); end
      #1;
      rst = 1'b0;
      #1;
      n_cmp++; if (s_waitrequest !== 1'b0)   begin n_bad++; $display("FAIL mf_s_wait got %h want 0", s_waitrequest); end
      n_cmp++; if (m_read !== 1'b0)          begin n_bad++; $display("FAIL mf_m_read got %h want 0", m_read); end
      n_cmp++; if (m_write !== 1'b0)         begin n_bad++; $display("FAIL mf_m_write got %h want 0", m_write); end
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL mf_rdv got %h want 0", s_readdatavalid); end
      n_cmp++; if (s_readdata !== '0)        begin n_bad++; $display("FAIL mf_rdata got %h want 0", s_readdata); end
      n_cmp++; if (m_address !== '0)         begin n_bad++; $display("FAIL mf_addr got %h want 0", m_address); end
      n_cmp++; if (m_byteenable !== '0)      begin n_bad++; $display("FAIL mf_be got %h want 0", m_byteenable); end
      n_cmp++; if (m_writedata !== '0)       begin n_bad++; $display("FAIL mf_wdata got %h want 0", m_writedata); end
      @(negedge clk);
      rst = 1'b1; m_waitrequest = 1'b0;
      m_readdatavalid = 1'b1; m_readdata = $urandom;  // late response for a dropped read
      tick();
      m_readdatavalid = 1'b0;
      n_cmp++; if (err_unsolicited !== 1'b1) begin n_bad++; $display("FAIL mf_late_err got %h want 1", err_unsolicited); end
      n_cmp++; if (s_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL mf_late_rdv got %h want 0", s_readdatavalid); end
   endtask

   task automatic test_random();
      cmd_t              q[$];
      cmd_t              c;
      int                pend;
      bit                err_m, exp_rdv, exp_wait, acc, exp_mr, exp_mw;
      logic [DATA_W-1:0] exp_rdata;
      do_reset();
      pend = 0; err_m = 1'b0; exp_rdv = 1'b0; exp_rdata = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         s_read          = ($urandom % 10) < 4;
         s_write         = ($urandom % 10) < 3;
         s_address       = $urandom;
         s_byteenable    = BE_W'($urandom);
         s_writedata     = $urandom;
         m_waitrequest   = ($urandom % 10) < 3;
         m_readdatavalid = (pend > 0) ? (($urandom % 3) == 0) : (($urandom % 40) == 0);
         m_readdata      = $urandom;
         #1;
         exp_mr = (q.size() > 0) && q[0].rd;
         exp_mw = (q.size() > 0) && !q[0].rd;
         n_cmp++; if (m_read !== exp_mr)  begin n_bad++; $display("FAIL rnd_m_read cyc %0d got %h want %h", cyc, m_read, exp_mr); end
         n_cmp++; if (m_write !== exp_mw) begin n_bad++; $display("FAIL rnd_m_write cyc %0d got %h want %h", cyc, m_write, exp_mw); end
         if (q.size() > 0) begin
            c = q[0];
            n_cmp++; if (m_address !== c.addr)  begin n_bad++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, m_address, c.addr); end
            n_cmp++; if (m_byteenable !== c.be) begin n_bad++; $display("FAIL rnd_be cyc %0d got %h want %h", cyc, m_byteenable, c.be); end
            if (!c.rd) begin
               n_cmp++; if (m_writedata !== c.wd) begin n_bad++; $display("FAIL rnd_wdata cyc %0d got %h want %h", cyc, m_writedata, c.wd); end
            end
         end
         exp_wait = ((q.size() > 0) && m_waitrequest) || (s_read && pend == MAXP);
         n_cmp++; if (s_waitrequest !== exp_wait)  begin n_bad++; $display("FAIL rnd_wait cyc %0d got %h want %h", cyc, s_waitrequest, exp_wait); end
         n_cmp++; if (s_readdatavalid !== exp_rdv) begin n_bad++; $display("FAIL rnd_rdv cyc %0d got %h want %h", cyc, s_readdatavalid, exp_rdv); end
         n_cmp++; if (s_readdata !== exp_rdata)    begin n_bad++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cyc, s_readdata, exp_rdata); end
         n_cmp++; if (err_unsolicited !== err_m)   begin n_bad++; $display("FAIL rnd_err cyc %0d got %h want %h", cyc, err_unsolicited, err_m); end
         // advance the transaction model across the coming edge
         acc = (s_read || s_write) && !exp_wait;
         if ((q.size() > 0) && !m_waitrequest) void'(q.pop_front());
         if (acc) q.push_back('{s_read, s_address, s_byteenable, s_writedata});
         exp_rdv = m_readdatavalid && (pend > 0);
         if (exp_rdv) exp_rdata = m_readdata;
         if (m_readdatavalid && pend == 0) err_m = 1'b1;
         pend = pend + ((acc && s_read) ? 1 : 0) - (exp_rdv ? 1 : 0);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_write();
      test_backpressure();
      test_pending_limit();
      test_simultaneous();
      test_unsolicited();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/avalon_mm_bridge.md
AVALON_MM_BRIDGE -- requirements
Module: avalon_mm_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8; byteenable width BE_W = DATA_W/8).
REQ-003 SHALL have parameter MAX_PENDING, default 4, maximum outstanding reads (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-low reset).
REQ-005 Upstream agent side (from CPU host):
- s_address in ADDR_W
- s_byteenable in BE_W
- s_read in 1
- s_write in 1
- s_writedata in DATA_W
- s_waitrequest out 1
- s_readdata out DATA_W
- s_readdatavalid out 1
REQ-006 Downstream host side (to fabric):
- m_address out ADDR_W
- m_byteenable out BE_W
- m_read out 1
- m_write out 1
- m_writedata out DATA_W
- m_waitrequest in 1
- m_readdata in DATA_W
- m_readdatavalid in 1
REQ-007 SHALL have err_unsolicited, out, 1, sticky flag for a response received with no read outstanding.

Function
REQ-008 Command slice: SHALL hold one registered command (address, byteenable, writedata, type), tracked by a cmd_full bit.
REQ-009 Upstream accept SHALL occur in a cycle where (s_read | s_write) & !s_waitrequest.
REQ-010 s_waitrequest SHALL equal (cmd_full & m_waitrequest) | (s_read & pending == MAX_PENDING); the combinational path from m_waitrequest is intentional, so a draining slice accepts a new command in the same cycle.
REQ-011 On accept, the slice SHALL load the command, and cmd_full SHALL be 1 the next cycle.
REQ-012 m_read / m_write SHALL equal cmd_full & the stored type; m_address, m_byteenable and m_writedata SHALL come from the slice; m_read and m_write SHALL never both be 1.
REQ-013 Slice drain: when cmd_full & !m_waitrequest, the command is issued; cmd_full SHALL clear unless a new accept occurs in the same cycle.
REQ-014 Issue latency: a command accepted at edge N SHALL appear on the m_* outputs in cycle N+1 (minimum one cycle).
REQ-015 s_read & s_write both asserted SHALL be treated as a read only.
REQ-016 Pending counter: width clog2(MAX_PENDING+1); SHALL increment on read accept and decrement on m_readdatavalid when nonzero; simultaneous increment and decrement SHALL leave it unchanged.
REQ-017 Writes SHALL NOT affect pending; write completion is assumed at slice issue.
REQ-018 Response path: m_readdata / m_readdatavalid SHALL be registered into s_readdata / s_readdatavalid with exactly one cycle latency, in order, with no backpressure.
REQ-019 m_readdatavalid with pending == 0 SHALL NOT assert s_readdatavalid, SHALL leave pending at 0, and SHALL set err_unsolicited, which stays 1 until reset.
REQ-020 s_readdata SHALL hold its last value when s_readdatavalid is 0.
REQ-021 A write accept SHALL never be blocked by pending == MAX_PENDING.

Reset
REQ-022 While rst == 0, SHALL immediately force: cmd_full=0, pending=0, m_read=0, m_write=0, s_readdatavalid=0, s_waitrequest=0 (given s_read=0), err_unsolicited=0, and s_readdata, m_address, m_byteenable, m_writedata = 0.
REQ-023 Reset mid-operation SHALL drop the slice contents and all pending counts; late responses arriving after reset SHALL be flagged per REQ-019.
REQ-024 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-025 Single read, m_waitrequest=0: s_read at 0x100 -> m_read at 0x100 next cycle; m_readdatavalid with 0xDEADBEEF -> s_readdatavalid with 0xDEADBEEF one cycle later; pending returns to 0.
REQ-026 Backpressure: m_waitrequest held 1 for 3 cycles with slice full -> s_waitrequest=1 for those cycles, m_read stable at the same address; on release, back-to-back accept in the same cycle.
REQ-027 Pending limit: MAX_PENDING=4, five reads with no responses -> fifth read sees s_waitrequest=1; a concurrent write is still accepted; one response -> fifth read accepted.
REQ-028 Simultaneous read accept and m_readdatavalid at pending=2 -> pending stays 2.
REQ-029 Unsolicited response at pending=0 -> err_unsolicited=1 and s_readdatavalid=0; after assert/deassert of rst -> err_unsolicited=0.
REQ-030 Reset mid-flight: assert rst with cmd_full=1 and pending=3 -> all outputs reach REQ-022 values without a clock edge.
